// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } md_state_t;

  // Arithmetic ops occupy codes 0..3.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Among arithmetic ops, even codes are the signed variants.
  function automatic logic is_signed_op(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh  = acc_in[2*WIDTH-1:WIDTH-1];
    ge      = (rem_sh >= {1'b0, opnd});
    diff    = rem_sh[WIDTH-1:0] - opnd;
    acc_out = acc_in;
    if (is_div) begin
      if (ge) acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
      else    acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_in[0]) acc_out = {sum, acc_in[WIDTH-1:1]};
      else           acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with HI/LO registers and datapath stall.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  md_state_t          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;    // negate product / quotient
  logic               rneg_q, rneg_d;  // remainder takes dividend sign
  logic               dz_q, dz_d;      // divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] step_out;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_q),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (step_out)
  );

  // Next-state, operand latching, sign fixup and HI/LO write selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done     = 1'b0;
    stall    = (state_q != StIdle);
    a_neg    = is_signed_op(op) & srca[WIDTH-1];
    b_neg    = is_signed_op(op) & srcb[WIDTH-1];
    a_mag    = a_neg ? -srca : srca;
    b_mag    = b_neg ? -srcb : srcb;
    prod_fix = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_arith(op)) begin
            stall   = 1'b1;
            state_d = StRun;
            cnt_d   = '0;
            div_d   = is_div_op(op);
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (srcb == '0);
            if (is_div_op(op)) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end else if (op == MD_MTHI) begin
            hi_d = srca;
          end else if (op == MD_MTLO) begin
            lo_d = srca;
          end
        end
      end
      StRun: begin
        acc_d = step_out;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StFix;
          cnt_d   = '0;
        end
      end
      StFix: begin
        done    = 1'b1;
        state_d = StIdle;
        if (div_q) begin
          // Divide by zero: the restoring loop already leaves |a| as remainder.
          hi_d = rem;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, stall32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, stall8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .srca(a32), .srcb(b32),
    .stall(stall32), .done(done32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .srca(a8), .srcb(b8),
    .stall(stall8), .done(done8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic s, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = s; op32 = o; a32 = a; b32 = b;
    end
  endtask

  // Issue one op and follow it until stall drops (cycle 0 = request cycle).
  // inj_at >= 1 raises a spurious start with other operands during that cycle.
  task automatic run(input bit w8, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int inj_at,
                     output logic [31:0] rh, output logic [31:0] rl,
                     output int lat, output int nstall, output int ndone, output int dcyc);
    logic s, d;
    @(posedge clk); #1;
    drive(w8, 1'b1, o, a, b);
    lat = -1; nstall = 0; ndone = 0; dcyc = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      s = w8 ? stall8 : stall32;
      d = w8 ? done8 : done32;
      if (s) nstall++;
      if (d) begin ndone++; dcyc = c; end
      if (c > 0 && !s) begin lat = c; break; end
      @(posedge clk); #1;
      if (c + 1 == inj_at) drive(w8, 1'b1, MD_MULTU, 32'h3, 32'h3);
      else                 drive(w8, 1'b0, o, a, b);
    end
    drive(w8, 1'b0, o, a, b);
    rh = w8 ? {24'h0, hi8} : hi32;
    rl = w8 ? {24'h0, lo8} : lo32;
  endtask

  vec_t        vecs[12];
  logic [31:0] rh, rl;
  int          lat, ns, nd, dc;

  initial begin
    vecs[0]  = '{MD_MULTU, 32'd7,          32'd6,          32'h0,        32'd42};
    vecs[1]  = '{MD_MULT,  32'h80000000,   32'd2,          32'hFFFFFFFF, 32'h0};
    vecs[2]  = '{MD_MULT,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'h0,        32'h1};
    vecs[3]  = '{MD_DIV,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{MD_DIVU,  32'd100,        32'd7,          32'd2,        32'd14};
    vecs[5]  = '{MD_DIV,   32'h80000000,   32'hFFFFFFFF,   32'h0,        32'h80000000};
    vecs[6]  = '{MD_DIVU,  32'h1234,       32'h0,          32'h1234,     32'hFFFFFFFF};
    vecs[7]  = '{MD_DIV,   32'hFFFFFFFB,   32'h0,          32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{MD_MULT,  32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[9]  = '{MD_DIV,   32'd7,          32'hFFFFFFFE,   32'd1,        32'hFFFFFFFD};
    vecs[10] = '{MD_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h1};
    vecs[11] = '{MD_DIVU,  32'hFFFFFFFF,   32'd1,          32'h0,        32'hFFFFFFFF};

    reset = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_stall", stall32, 0);
    check("rst_done", done32, 0);
    check("rst_hi", hi32, 0);
    check("rst_lo", lo32, 0);
    check("rst_stall8", stall8, 0);

    for (int i = 0; i < 12; i++) begin
      run(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, -1, rh, rl, lat, ns, nd, dc);
      check($sformatf("v%0d_hi", i), rh, vecs[i].eh);
      check($sformatf("v%0d_lo", i), rl, vecs[i].el);
      check($sformatf("v%0d_latency", i), lat, 34);
      check($sformatf("v%0d_stall_cycles", i), ns, 34);
      check($sformatf("v%0d_done_count", i), nd, 1);
      check($sformatf("v%0d_done_cycle", i), dc, 33);
    end

    // Spurious start mid-RUN must not disturb the running DIVU.
    run(1'b0, MD_DIVU, 32'd100, 32'd7, 5, rh, rl, lat, ns, nd, dc);
    check("inj_hi", rh, 32'd2);
    check("inj_lo", rl, 32'd14);
    check("inj_latency", lat, 34);
    check("inj_done_count", nd, 1);

    // Reset during RUN cycle 10 of a DIV aborts without writing HI/LO.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, MD_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_stall", stall32, 0);
    check("abort_done", done32, 0);
    check("abort_hi", hi32, 0);
    check("abort_lo", lo32, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) nd++;
    end
    check("abort_no_done", nd, 0);
    check("abort_lo_kept", lo32, 0);

    // Direct HI/LO writes: one cycle, no stall, no done.
    run(1'b0, MD_MTHI, 32'hA5, 32'h0, -1, rh, rl, lat, ns, nd, dc);
    check("mthi_hi", rh, 32'hA5);
    check("mthi_lo_untouched", rl, 32'h0);
    check("mthi_stall", ns, 0);
    check("mthi_done", nd, 0);
    run(1'b0, MD_MTLO, 32'h5A, 32'h0, -1, rh, rl, lat, ns, nd, dc);
    check("mtlo_hi", rh, 32'hA5);
    check("mtlo_lo", rl, 32'h5A);
    check("mtlo_stall", ns, 0);
    check("mtlo_done", nd, 0);
    run(1'b0, 3'd6, 32'h77, 32'h1, -1, rh, rl, lat, ns, nd, dc);
    check("op6_hi", rh, 32'hA5);
    check("op6_lo", rl, 32'h5A);
    check("op6_stall", ns, 0);

    // WIDTH=8: signed corner and back-to-back issue.
    run(1'b1, MD_MULT, 32'h80, 32'h80, -1, rh, rl, lat, ns, nd, dc);
    check("w8_mult_hi", rh, 32'h40);
    check("w8_mult_lo", rl, 32'h00);
    check("w8_mult_latency", lat, 10);
    check("w8_mult_done_cycle", dc, 9);
    run(1'b1, MD_MULTU, 32'h0F, 32'h11, -1, rh, rl, lat, ns, nd, dc);
    check("w8_first_lo", rl, 32'hFF);
    check("w8_first_hi", rh, 32'h00);
    // Still in the cycle where stall dropped: issue the next op now.
    drive(1'b1, 1'b1, MD_MULTU, 32'hFF, 32'hFF);
    #1;
    check("w8_b2b_stall", stall8, 1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, MD_MULTU, 32'hFF, 32'hFF);
    dc = -1;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      if (done8) begin dc = c; break; end
      @(posedge clk); #1;
    end
    check("w8_b2b_done_cycle", dc, 9);
    @(negedge clk);
    check("w8_b2b_hi", hi8, 8'hFE);
    check("w8_b2b_lo", lo8, 8'h01);
    check("w8_b2b_stall_low", stall8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, feeding the multi-cycle datapath's ALU stage. Executes signed/unsigned multiply and divide by radix-2 shift-add/restoring iteration, raises `stall` to freeze the datapath while busy, and supports direct HI/LO writes. It replaces the fixed 32-bit stalling mult/div path with one generic in operand width.

## Interface
- `WIDTH`, 32, operand and HI/LO width; any value ≥ 4.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  sample `op`/`srca`/`srcb` this cycle (honoured only in IDLE)
- `op`  in  3  `md_op_t` operation code
- `srca`  in  WIDTH  multiplicand / dividend / MTHI-MTLO data
- `srcb`  in  WIDTH  multiplier / divisor
- `stall`  out  1  datapath hold request
- `done`  out  1  one-cycle pulse, HI/LO updated by an arithmetic op this cycle
- `hi`  out  WIDTH  HI register (product upper half / remainder)
- `lo`  out  WIDTH  LO register (product lower half / quotient)

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1:
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes (|x| for signed ops, raw for unsigned) and result sign flags, clear count, go RUN.
  - MTHI/MTLO: write `srca` into `hi`/`lo` at this edge, stay IDLE, no stall.
  - codes 6,7: ignored.
- RUN: one iteration per cycle, counter 0..WIDTH-1; leave for FIX after iteration WIDTH-1.
  - Multiply: 2·WIDTH-bit accumulator, add multiplicand if multiplier LSB set, shift right.
  - Divide: restoring; shift remainder left, subtract divisor, keep if non-negative, quotient bit = 1.
- FIX: apply sign correction and write `hi`/`lo`, assert `done`, go IDLE.
  - Signed multiply: negate 2·WIDTH product if sign(a)≠sign(b).
  - Signed divide: quotient truncates toward zero (negate if signs differ); remainder takes dividend sign.
  - Most-negative / −1: `lo`=most-negative, `hi`=0 (falls out of magnitude arithmetic; no special case needed).
  - Divide by zero (both signednesses): `hi`=`srca` as latched, `lo`=all ones. Decided, not undefined.
- `start` while RUN/FIX: ignored; inputs not re-sampled.
- `hi`/`lo` change only at MTHI/MTLO, FIX, or reset.

## Timing
- Reset: state IDLE, `hi`=0, `lo`=0, `stall`=0, `done`=0, counter 0. Reset mid-RUN/FIX aborts; no partial write.
- `stall` = (IDLE & `start` & op ∈ arithmetic) | (state ≠ IDLE); combinational from `start` in the request cycle so the datapath holds immediately.
- Arithmetic op started cycle 0: RUN cycles 1..WIDTH, FIX cycle WIDTH+1; `stall` high cycles 0..WIDTH+1; `done` high cycle WIDTH+1; new `hi`/`lo` visible from cycle WIDTH+2. Latency fixed at WIDTH+2 regardless of operands.
- `stall` low in cycle WIDTH+2; a new `start` may be accepted that same cycle (back-to-back issue, no bubble beyond FIX).
- MTHI/MTLO: value visible the cycle after `start`.
- `done` never asserts for MTHI/MTLO.

## Structure
- `muldiv_pkg`: `md_op_t` enum (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5), state enum `md_state_t`, helper predicate is-arithmetic.
- One sub-module: `muldiv_step`, combinational single-iteration datapath (shift-add or restore-subtract selected by mode), WIDTH-parameterised; FSM, counter, sign fixup and HI/LO registers stay in `muldiv_unit`.
- Counter width `$clog2(WIDTH)`.

## Test plan
- MULTU 7×6, WIDTH=32 -> `stall` high 34 cycles, `done` at cycle 33, `hi`=0, `lo`=42.
- MULT 0x80000000×2 -> `hi`=0xFFFFFFFF, `lo`=0x00000000; MULT 0xFFFFFFFF×0xFFFFFFFF -> `hi`=0, `lo`=1.
- DIV −7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 100/7 -> `lo`=14, `hi`=2; DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU 0x1234/0 -> `hi`=0x1234, `lo`=0xFFFFFFFF; MTHI 0xA5 then MTLO 0x5A -> `hi`=0xA5, `lo`=0x5A, `stall` never high.
- Reset asserted at RUN cycle 10 of a DIV -> next cycle IDLE, `hi`=`lo`=0, `stall`=0, no `done`; `start` during RUN with different operands -> ignored, original result delivered.
- WIDTH=8 instance: MULT 0x80×0x80 -> `hi`=0x40, `lo`=0x00, latency 10; back-to-back MULTU issued the cycle `stall` drops -> accepted, second result correct.
